// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: state enum, opcode/funct
// fields, ALU operations and datapath mux codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd15
    } state_t;

    localparam state_t RESET_STATE = FETCH;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Read/write strobes, grouped so hold and reset can gate them together.
    typedef struct packed {
        logic pcWrite;
        logic pcWriteCond;
        logic irWrite;
        logic memRead;
        logic memWrite;
        logic regWrite;
    } strobe_t;

    typedef struct packed {
        logic       iOrD;
        logic       memToReg;
        logic [1:0] pcSource;
        logic [2:0] aluControl;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       regDst;
    } select_t;

    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and hold in, control strobes
// and mux selects out.
interface mc_ctrl_if;
    logic       hold;
    logic [5:0] op;
    logic [5:0] funct;
    logic       pcWriteCond;
    logic       pcWrite;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic [1:0] pcSource;
    logic [2:0] aluControl;
    logic [1:0] aluSrcB;
    logic       aluSrcA;
    logic       regWrite;
    logic       regDst;

    modport master (
        input  hold, op, funct,
        output pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
               pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst
    );

    modport slave (
        output hold, op, funct,
        input  pcWriteCond, pcWrite, iOrD, memRead, memWrite, memToReg, irWrite,
               pcSource, aluControl, aluSrcB, aluSrcA, regWrite, regDst
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct -> ALU operation; funct_valid flags encodings the ALU cannot run.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] aluControl,
    output logic       funct_valid
);

    always_comb begin
        aluControl  = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  aluControl = ALU_ADD;
            FN_SUB:  aluControl = ALU_SUB;
            FN_AND:  aluControl = ALU_AND;
            FN_OR:   aluControl = ALU_OR;
            FN_SLT:  aluControl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath. Build with MC_CTRL_PERF_EN
// defined to add the cycle_count / instr_count performance counters.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus,
    output logic        illegal,
    output logic [3:0]  state_dbg
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    state_t     state, nextState;
    strobe_t    stb;
    select_t    sel;
    logic [2:0] rAluControl;
    logic       functValid;

    alu_decoder uAluDec (
        .funct       (bus.funct),
        .aluControl  (rAluControl),
        .funct_valid (functValid)
    );

    // State register; illegal latches on the edge that enters TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RESET_STATE;
            illegal <= 1'b0;
        end else if (!bus.hold) begin
            state <= nextState;
            if (nextState == TRAP) illegal <= 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:  nextState = DECODE;
            DECODE: begin
                if (isMemOp(bus.op))           nextState = MEM_ADR;
                else if (bus.op == OP_RTYPE)   nextState = R_EXEC;
                else if (bus.op == OP_BEQ)     nextState = BRANCH;
                else if (bus.op == OP_J)       nextState = JUMP;
                else if (bus.op == OP_ADDI)    nextState = ADDI_EXEC;
                else                           nextState = TRAP;
            end
            MEM_ADR:   nextState = (bus.op == OP_LW) ? MEM_RD :
                                   (bus.op == OP_SW) ? MEM_WR : TRAP;
            MEM_RD:    nextState = MEM_WB;
            MEM_WB:    nextState = FETCH;
            MEM_WR:    nextState = FETCH;
            R_EXEC:    nextState = functValid ? R_WB : TRAP;
            R_WB:      nextState = FETCH;
            BRANCH:    nextState = FETCH;
            JUMP:      nextState = FETCH;
            ADDI_EXEC: nextState = ADDI_WB;
            ADDI_WB:   nextState = FETCH;
            TRAP:      nextState = TRAP;
            default:   nextState = TRAP;
        endcase
    end

    always_comb begin
        stb = '0;
        sel = '0;
        case (state)
            FETCH: begin
                stb.memRead    = 1'b1;
                stb.irWrite    = 1'b1;
                stb.pcWrite    = 1'b1;
                sel.aluSrcB    = SRCB_FOUR;
                sel.aluControl = ALU_ADD;
                sel.pcSource   = PCSRC_ALU;
            end
            DECODE: begin
                sel.aluSrcB    = SRCB_IMM;
                sel.aluControl = ALU_ADD;
            end
            MEM_ADR, ADDI_EXEC: begin
                sel.aluSrcA    = 1'b1;
                sel.aluSrcB    = SRCB_IMM;
                sel.aluControl = ALU_ADD;
            end
            MEM_RD: begin
                stb.memRead = 1'b1;
                sel.iOrD    = 1'b1;
            end
            MEM_WB: begin
                stb.regWrite = 1'b1;
                sel.memToReg = 1'b1;
            end
            MEM_WR: begin
                stb.memWrite = 1'b1;
                sel.iOrD     = 1'b1;
            end
            R_EXEC: begin
                sel.aluSrcA    = 1'b1;
                sel.aluSrcB    = SRCB_REGB;
                sel.aluControl = rAluControl;
            end
            R_WB: begin
                stb.regWrite = 1'b1;
                sel.regDst   = 1'b1;
            end
            BRANCH: begin
                stb.pcWriteCond = 1'b1;
                sel.aluSrcA     = 1'b1;
                sel.aluSrcB     = SRCB_REGB;
                sel.aluControl  = ALU_SUB;
                sel.pcSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                stb.pcWrite  = 1'b1;
                sel.pcSource = PCSRC_JUMP;
            end
            ADDI_WB:  stb.regWrite = 1'b1;
            default: ;
        endcase
        // Held cycles must not commit anything (no double PC increment in FETCH).
        if (reset || bus.hold) stb = '0;
        if (reset) sel = '0;
    end

    assign bus.pcWrite     = stb.pcWrite;
    assign bus.pcWriteCond = stb.pcWriteCond;
    assign bus.irWrite     = stb.irWrite;
    assign bus.memRead     = stb.memRead;
    assign bus.memWrite    = stb.memWrite;
    assign bus.regWrite    = stb.regWrite;
    assign bus.iOrD        = sel.iOrD;
    assign bus.memToReg    = sel.memToReg;
    assign bus.pcSource    = sel.pcSource;
    assign bus.aluControl  = sel.aluControl;
    assign bus.aluSrcB     = sel.aluSrcB;
    assign bus.aluSrcA     = sel.aluSrcA;
    assign bus.regDst      = sel.regDst;
    assign state_dbg       = state;

`ifdef MC_CTRL_PERF_EN
    // An instruction retires when a completing state hands back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (!bus.hold) begin
            cycle_count <= cycle_count + 32'd1;
            if (state != FETCH && nextState == FETCH) instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM that sequences the multicycle MIPS datapath: fetch, decode, execute, memory and write-back steps.
- Drives every datapath control strobe from a registered state plus the opcode/funct fields returned by the datapath.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.
- Traps illegal encodings into a sticky halt state.

Parameters:
- RESET_STATE, FETCH, state entered on reset; fixed encoding from the package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- hold  in  1  freeze request; state frozen and all strobes gated
- op  in  6  instruction[31:26] from the datapath
- funct  in  6  instruction[5:0] from the datapath
- pcWriteCond  out  1  conditional PC write (on ALU zero)
- pcWrite  out  1  unconditional PC write
- iOrD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- memToReg  out  1  register write data select: 0=ALUOut, 1=MDR
- irWrite  out  1  instruction register load
- pcSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- aluControl  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- aluSrcB  out  2  ALU B select: 00=regB, 01=constant 4, 10=sign-extended imm16
- aluSrcA  out  1  ALU A select: 0=PC, 1=regA
- regWrite  out  1  register file write enable
- regDst  out  1  destination register select: 0=rt, 1=rd
- illegal  out  1  sticky trap flag
- state_dbg  out  4  current state encoding

Behaviour:
- Clocking and reset:
  - Single state register, rising clk.
  - reset=1 at a clock edge: state<=FETCH and illegal<=0. This takes priority over hold and over any in-flight instruction; a reset mid-instruction abandons that instruction.
  - While reset=1, all write/read strobes (pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite) are 0. All select outputs are 0.
- Outputs are pure decode of the state register (Moore). They do not depend combinationally on op or funct, except aluControl in R_EXEC, which is decoded from funct.
- Unlisted outputs are 0 in every state. Per-state values:
  - FETCH: memRead=1, iOrD=0, irWrite=1, aluSrcA=0, aluSrcB=01, aluControl=ADD, pcWrite=1, pcSource=00. Next: DECODE.
  - DECODE: aluSrcA=0, aluSrcB=10, aluControl=ADD (branch target to ALUOut; offset in bytes relative to PC+4). Next by op:
    - 100011/101011 -> MEM_ADR
    - 000000 -> R_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> ADDI_EXEC
    - other -> TRAP
  - MEM_ADR: aluSrcA=1, aluSrcB=10, ADD. Next: lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD: memRead=1, iOrD=1. Next: MEM_WB.
  - MEM_WB: regWrite=1, memToReg=1, regDst=0. Next: FETCH.
  - MEM_WR: memWrite=1, iOrD=1. Next: FETCH.
  - R_EXEC: aluSrcA=1, aluSrcB=00, aluControl from funct:
    - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT
    - unknown funct: next is TRAP instead of R_WB.
  - R_WB: regWrite=1, regDst=1, memToReg=0. Next: FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, SUB, pcWriteCond=1, pcSource=01. Next: FETCH.
  - JUMP: pcWrite=1, pcSource=10. Next: FETCH.
  - ADDI_EXEC: aluSrcA=1, aluSrcB=10, ADD. Next: ADDI_WB.
  - ADDI_WB: regWrite=1, regDst=0, memToReg=0. Next: FETCH.
  - TRAP: all strobes 0, illegal=1. Stays in TRAP until reset.
- Latency in cycles, FETCH inclusive: lw 5; sw, R-type and addi 4; beq and j 3.
- hold=1: state unchanged at the edge, and all six strobes forced 0 that cycle. Selects keep their state values. Resume continues the same state.
- hold=1 in FETCH must not double-increment the PC: the PC write is gated.
- The illegal flag is set on the edge entering TRAP. hold does not clear it.

Optional Feature:
- MC_CTRL_PERF_EN defined: adds two 32-bit outputs.
  - cycle_count: increments every non-held, non-reset cycle.
  - instr_count: increments on each transition into FETCH from a completing state.
  - Both counters reset to 0 and wrap modulo 2^32.
- MC_CTRL_PERF_EN undefined: both ports and both counters are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum, 4-bit
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - funct constants
  - ALU control encodings
  - aluSrcB and pcSource codes
- One sub-module: alu_decoder, combinational funct -> {aluControl, funct_valid}, instantiated for R_EXEC.

Test Plan:
- Reset held 3 cycles, then op=100011: state_dbg sequence FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, FETCH. MEM_RD has iOrD=1 and memRead=1; MEM_WB has regWrite=1 and memToReg=1.
- op=000000, funct=101010: R_EXEC has aluControl=111; R_WB has regWrite=1 and regDst=1; back at FETCH on cycle 5.
- op=000100: BRANCH has pcWriteCond=1, pcSource=01, aluControl=110, pcWrite=0; 3 cycles total. op=000010: JUMP has pcSource=10 and pcWrite=1.
- op=111111 at DECODE, or op=000000 with funct=000111 at R_EXEC: enters TRAP, illegal=1 and held with all strobes 0 for 10 cycles. reset clears illegal and returns to FETCH.
- hold=1 for 4 cycles in FETCH, then in MEM_WR: state_dbg constant, pcWrite/irWrite/memWrite=0 while held. Release: a single PC write and a single memWrite pulse.
- With MC_CTRL_PERF_EN: run lw, sw, beq, j back-to-back. Expect instr_count=4 and cycle_count=15; reset mid-sw returns both counters to 0.
